fpu_unpack: RTL and testbench

FPU_UNPACK -- requirements
Module: fpu_unpack

---
 rtl/fpu_unpack.sv | 34 +++
 tb/tb_fpu_unpack.sv | 101 ++++++++++
 2 files changed

// File: rtl/fpu_unpack.sv
// fpu_unpack: registers sign, raw exponent and hidden-bit significand of two IEEE-754 singles.
module fpu_unpack (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_operand_a,
  input  logic [31:0] in_operand_b,
  input  logic [1:0]  in_operator,
  output logic        sign_1,
  output logic        sign_2,
  output logic [7:0]  exponent_1,
  output logic [7:0]  exponent_2,
  output logic [23:0] mantissa_1,
  output logic [23:0] mantissa_2,
  output logic [1:0]  operator
);
  always_ff @(posedge clk)
    if (reset) begin
      sign_1     <= 1'b0;
      sign_2     <= 1'b0;
      exponent_1 <= 8'h00;
      exponent_2 <= 8'h00;
      mantissa_1 <= 24'h000000;
      mantissa_2 <= 24'h000000;
      operator   <= 2'b00;
    end else begin
      sign_1     <= in_operand_a[31];
      sign_2     <= in_operand_b[31];
      exponent_1 <= in_operand_a[30:23];
      exponent_2 <= in_operand_b[30:23];
      mantissa_1 <= {|in_operand_a[30:23], in_operand_a[22:0]};
      mantissa_2 <= {|in_operand_b[30:23], in_operand_b[22:0]};
      operator   <= in_operator;
    end
endmodule

// File: tb/tb_fpu_unpack.sv
// tb_fpu_unpack: directed and random operand pairs checked against an arithmetic unpack model.
module tb_fpu_unpack;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_operand_a, in_operand_b;
  logic [1:0]  in_operator;
  logic        sign_1, sign_2;
  logic [7:0]  exponent_1, exponent_2;
  logic [23:0] mantissa_1, mantissa_2;
  logic [1:0]  operator;
  int checks = 0;
  int failures = 0;
  longint unsigned e_s1, e_s2, e_x1, e_x2, e_m1, e_m2, e_op;
  bit have_ref = 0;

  fpu_unpack dut (
    .clk(clk), .reset(reset),
    .in_operand_a(in_operand_a), .in_operand_b(in_operand_b), .in_operator(in_operator),
    .sign_1(sign_1), .sign_2(sign_2),
    .exponent_1(exponent_1), .exponent_2(exponent_2),
    .mantissa_1(mantissa_1), .mantissa_2(mantissa_2),
    .operator(operator)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model(input longint unsigned x, output longint unsigned s,
                       output longint unsigned e, output longint unsigned m);
    s = x / (64'd1 << 31);
    e = (x / (64'd1 << 23)) % 256;
    m = x % (64'd1 << 23) + ((e != 0) ? (64'd1 << 23) : 0);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sign_1"}, sign_1, e_s1);
    check({tag, ".sign_2"}, sign_2, e_s2);
    check({tag, ".exponent_1"}, exponent_1, e_x1);
    check({tag, ".exponent_2"}, exponent_2, e_x2);
    check({tag, ".mantissa_1"}, mantissa_1, e_m1);
    check({tag, ".mantissa_2"}, mantissa_2, e_m2);
    check({tag, ".operator"}, operator, e_op);
  endtask

  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic r);
    in_operand_a = a;
    in_operand_b = b;
    in_operator  = op;
    reset        = r;
    #1;
    if (have_ref) check_all({tag, ".hold"});
    @(posedge clk);
    #1;
    if (r) begin
      e_s1 = 0; e_s2 = 0; e_x1 = 0; e_x2 = 0; e_m1 = 0; e_m2 = 0; e_op = 0;
    end else begin
      model(a, e_s1, e_x1, e_m1);
      model(b, e_s2, e_x2, e_m2);
      e_op = op;
    end
    have_ref = 1;
    check_all(tag);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 3))
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    @(negedge clk);
    step("reset_a", 32'h42AF0000, 32'h40A80000, 2'b11, 1'b1);
    step("zero", 32'h00000000, 32'h00000000, 2'b00, 1'b0);
    step("norm_1p25_1p5", 32'h3FA00000, 32'h3FC00000, 2'b00, 1'b0);
    step("norm_big", 32'h42AF0000, 32'h40A80000, 2'b00, 1'b0);
    step("denorm_neg1", 32'h00000001, 32'hBF800000, 2'b00, 1'b0);
    step("b2b_op10", 32'hC0490FDB, 32'h7F7FFFFF, 2'b10, 1'b0);
    step("b2b_op01", 32'h807FFFFF, 32'h7F800000, 2'b01, 1'b0);
    step("nan_inf", 32'h7FC00001, 32'hFF800000, 2'b11, 1'b0);
    step("reset_mid", 32'h42AF0000, 32'h40A80000, 2'b10, 1'b1);
    step("after_reset", 32'h42AF0000, 32'h40A80000, 2'b00, 1'b0);
    for (int i = 0; i < 300; i++)
      step("rand", rand_fp(), rand_fp(), 2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
